// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic inter-stage pipeline register carrying a control and a
// data bundle between adjacent core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Latency: one cycle (accepted at edge N, visible in cycle N+1).
// Backpressure: valid/ready on both sides. A synchronous flush kills held entries
// and the input of the same cycle.
// Optional feature macro: PIPE_STAGE_SKID_EN.
//   Defined: 2-entry skid buffer, and in_ready is driven from registered state only.
//   Undefined: single entry, and in_ready = !out_valid | out_ready (combinational).
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_ctrl/in_data upstream bundles
//   out_valid/out_ready  downstream handshake; out_ctrl/out_data head bundles
//   flush                drop all held entries and this cycle's input
//   count                number of held entries (0..2)
module pipe_stage_reg #(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 179
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        count
);

  // The state encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
`endif

  logic accept;
  logic take;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
`endif
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    // Only the registered state is used, so the hazard unit's stall signal
    // never ripples combinationally back into the previous stage.
    in_ready = (state_q != FULL);
`else
    in_ready = !out_valid || out_ready;
`endif
    accept = in_valid && in_ready;
    take   = out_valid && out_ready;

    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
`endif

    if (flush) begin
      // A head taken in the same cycle was already seen downstream; the
      // data registers keep their contents, only occupancy is dropped.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (take) begin
            if (accept) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end else begin
              state_d = EMPTY;
            end
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (take) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = BUSY;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // Bubbles must never carry write-enables downstream.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;
  assign count    = state_q;

endmodule
